// File: rtl/reg_bus_master_if.sv
// Register-bus master port bundle: host command/write/read streams plus the
// cwusb_clk register-bus strobes. master = initiator view, slave = host + responders.
interface reg_bus_master_if #(
  parameter int pBYTECNT_SIZE = 7
) ();
  logic                     I_cmd_valid;
  logic                     O_cmd_ready;
  logic                     I_cmd_write;
  logic [7:0]               I_cmd_addr;
  logic [pBYTECNT_SIZE-1:0] I_cmd_len;

  logic [7:0]               I_wdata;
  logic                     I_wdata_valid;
  logic                     O_wdata_ready;

  logic [7:0]               O_rdata;
  logic                     O_rdata_valid;
  logic                     I_rdata_ready;

  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               write_data;
  logic                     reg_write;
  logic                     reg_read;
  logic                     reg_addrvalid;
  logic [7:0]               read_data;

  logic                     O_busy;
  logic                     O_error;

  modport master (
    input  I_cmd_valid, I_cmd_write, I_cmd_addr, I_cmd_len,
    input  I_wdata, I_wdata_valid, I_rdata_ready, read_data,
    output O_cmd_ready, O_wdata_ready, O_rdata, O_rdata_valid,
    output reg_address, reg_bytecnt, write_data, reg_write, reg_read, reg_addrvalid,
    output O_busy, O_error
  );

  modport slave (
    output I_cmd_valid, I_cmd_write, I_cmd_addr, I_cmd_len,
    output I_wdata, I_wdata_valid, I_rdata_ready, read_data,
    input  O_cmd_ready, O_wdata_ready, O_rdata, O_rdata_valid,
    input  reg_address, reg_bytecnt, write_data, reg_write, reg_read, reg_addrvalid,
    input  O_busy, O_error
  );
endinterface

// File: rtl/reg_bus_master.sv
// Initiator for the cwusb_clk register bus: command/data byte streams in, one-cycle
// reg_write/reg_read strobes out. Define REG_MASTER_TIMEOUT_EN to add the stall watchdog.
module reg_bus_master #(
  parameter int pBYTECNT_SIZE  = 7,
  parameter int pTIMEOUT_WIDTH = 16
) (
  input logic              cwusb_clk,
  input logic              reset_i,
  reg_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WR, S_WR_STB, S_RD_REQ, S_RD_CAP, S_RD_HOLD, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               addr_q;
  logic [7:0]               wdata_q;
  logic [7:0]               rdata_q;
  logic [pBYTECNT_SIZE-1:0] len_q;
  logic [pBYTECNT_SIZE-1:0] cnt_q;
  logic                     write_q;
  logic                     rvalid_q;
  logic                     error_q;
  logic                     last_byte;
  logic                     abort;

  logic cmd_ready_c, wdata_ready_c, reg_write_c, reg_read_c, addrvalid_c, busy_c;

  assign last_byte = (cnt_q == len_q - 1'b1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cmd_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    reg_write_c   = 1'b0;
    reg_read_c    = 1'b0;
    addrvalid_c   = 1'b1;
    busy_c        = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        addrvalid_c = 1'b0;
        busy_c      = 1'b0;
        if (bus.I_cmd_valid) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (len_q == '0)  state_d = S_DONE;
        else if (write_q) state_d = S_WR;
        else              state_d = S_RD_REQ;
      end
      S_WR: begin
        wdata_ready_c = 1'b1;
        if (abort)                  state_d = S_DONE;
        else if (bus.I_wdata_valid) state_d = S_WR_STB;
      end
      S_WR_STB: begin
        reg_write_c = 1'b1;
        state_d     = last_byte ? S_DONE : S_WR;
      end
      S_RD_REQ: begin
        reg_read_c = 1'b1;
        state_d    = S_RD_CAP;
      end
      S_RD_CAP: state_d = S_RD_HOLD;
      S_RD_HOLD: begin
        if (abort)                  state_d = S_DONE;
        else if (bus.I_rdata_ready) state_d = last_byte ? S_DONE : S_RD_REQ;
      end
      S_DONE: begin
        addrvalid_c = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cwusb_clk) begin
    // NOTE: all datapath registers are reset too, so a dropped burst leaves no stale byte on the outputs.
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.I_cmd_valid) begin
            addr_q  <= bus.I_cmd_addr;
            len_q   <= bus.I_cmd_len;
            write_q <= bus.I_cmd_write;
            cnt_q   <= '0;
          end
        end
        S_WR: begin
          if (bus.I_wdata_valid) wdata_q <= bus.I_wdata;
        end
        // Byte index moves only after the strobe so it is stable during reg_write.
        S_WR_STB: cnt_q <= cnt_q + 1'b1;
        S_RD_CAP: begin
          rdata_q  <= bus.read_data;
          rvalid_q <= 1'b1;
        end
        S_RD_HOLD: begin
          if (abort) begin
            rvalid_q <= 1'b0;
          end else if (bus.I_rdata_ready) begin
            rvalid_q <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        S_DONE: cnt_q <= '0;
        default: ;
      endcase
    end
  end

`ifdef REG_MASTER_TIMEOUT_EN
  localparam logic [pTIMEOUT_WIDTH-1:0] STALL_LAST = {pTIMEOUT_WIDTH{1'b1}} - 1'b1;

  logic [pTIMEOUT_WIDTH-1:0] stall_q;
  logic                      stalled;

  assign stalled = ((state_q == S_WR)      && !bus.I_wdata_valid) ||
                   ((state_q == S_RD_HOLD) && !bus.I_rdata_ready);
  // The stall that would take the counter to all-ones ends the burst.
  assign abort   = stalled && (stall_q == STALL_LAST);

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else begin
      stall_q <= (stalled && !abort) ? stall_q + 1'b1 : '0;
      if (abort) error_q <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign error_q = 1'b0;
`endif

  // O_cmd_ready is masked during reset so every output reads 0 while reset_i is high.
  assign bus.O_cmd_ready   = cmd_ready_c && !reset_i;
  assign bus.O_wdata_ready = wdata_ready_c;
  assign bus.O_rdata       = rdata_q;
  assign bus.O_rdata_valid = rvalid_q;
  assign bus.reg_address   = addr_q;
  assign bus.reg_bytecnt   = cnt_q;
  assign bus.write_data    = wdata_q;
  assign bus.reg_write     = reg_write_c;
  assign bus.reg_read      = reg_read_c;
  assign bus.reg_addrvalid = addrvalid_c;
  assign bus.O_busy        = busy_c;
  assign bus.O_error       = error_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed burst table, hand-written reset / len-0 / timeout
// sequences, and randomized bursts scored against a transaction-level model.
module tb_reg_bus_master;
  localparam int BCW = 7;

  logic cwusb_clk = 1'b0;
  logic reset_i;
  always #5 cwusb_clk = ~cwusb_clk;

  reg_bus_master_if #(.pBYTECNT_SIZE(BCW)) bus ();

  reg_bus_master #(.pBYTECNT_SIZE(BCW), .pTIMEOUT_WIDTH(4)) dut (
    .cwusb_clk (cwusb_clk),
    .reset_i   (reset_i),
    .bus       (bus)
  );

  typedef struct packed {
    logic [7:0]     addr;
    logic [BCW-1:0] cnt;
    logic [7:0]     data;
  } strobe_t;

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] addr;
    int         len;
    int         wstall;
    int         rstall;
    int         exp_strobes;
    int         exp_av;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         viol = 0;
  strobe_t    wr_seen[$];
  strobe_t    rd_seen[$];
  logic [7:0] resp_q[$];
  logic       prev_read = 1'b0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.reg_write, bus.reg_read, bus.reg_addrvalid, bus.O_busy,
            bus.O_cmd_ready, bus.O_wdata_ready, bus.O_rdata_valid, bus.O_error,
            bus.write_data, bus.O_rdata, bus.reg_address};
  endfunction

  // One cycle: sample at the falling edge, log strobes, check protocol rules, model responders.
  task automatic tick();
    @(negedge cwusb_clk);
    cyc++;
    if (bus.reg_write && bus.reg_read) viol++;
    if ((bus.reg_write || bus.reg_read) && !bus.reg_addrvalid) viol++;
    if (hold_pending && (!bus.O_rdata_valid || bus.O_rdata !== hold_data)) viol++;
    hold_pending = 1'b0;
    if (bus.reg_write) wr_seen.push_back({bus.reg_address, bus.reg_bytecnt, bus.write_data});
    if (bus.reg_read)  rd_seen.push_back({bus.reg_address, bus.reg_bytecnt, 8'h00});
    bus.read_data = (prev_read && resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
    prev_read = bus.reg_read;
  endtask

  task automatic wait_ready(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = bus.O_cmd_ready;
    end
    if (!ok) check({name, "_cmd_ready"}, 32'd0, 32'd1);
  endtask

  // Stall < 0 means a random 0..3 cycle delay before each handshake.
  task automatic do_burst(input string name, input logic wr, input logic [7:0] addr, input int len,
                          input int wstall, input int rstall, input logic [7:0] bytes[$],
                          output int av_cycles, output int lat);
    int         acc, idx, gap, need, done_cycles;
    logic       ok, finished;
    logic [7:0] got[$];
    wr_seen.delete();
    rd_seen.delete();
    viol = 0; av_cycles = 0; lat = -1; done_cycles = 0; idx = 0; gap = 0;
    if (wr) resp_q.delete(); else resp_q = bytes;
    need = wr ? wstall : rstall;
    if (need < 0) need = $urandom_range(0, 3);
    wait_ready(name, ok);
    if (!ok) return;
    bus.I_cmd_valid = 1'b1;
    bus.I_cmd_write = wr;
    bus.I_cmd_addr  = addr;
    bus.I_cmd_len   = BCW'(len);
    acc = cyc;
    finished = 1'b0;
    for (int i = 0; i < 5000 && !finished; i++) begin
      tick();
      bus.I_cmd_valid   = 1'b0;
      bus.I_wdata_valid = 1'b0;
      bus.I_rdata_ready = 1'b0;
      if (!bus.O_busy) begin
        finished = 1'b1;
      end else begin
        if (bus.reg_addrvalid) av_cycles++; else done_cycles++;
        if (bus.O_wdata_ready && idx < len) begin
          if (gap >= need) begin
            bus.I_wdata_valid = 1'b1;
            bus.I_wdata = bytes[idx];
            idx++; gap = 0;
            if (wstall < 0) need = $urandom_range(0, 3);
          end else gap++;
        end
        if (bus.O_rdata_valid) begin
          if (lat < 0) lat = cyc - acc - 1;
          if (gap >= need) begin
            bus.I_rdata_ready = 1'b1;
            got.push_back(bus.O_rdata);
            gap = 0;
            if (rstall < 0) need = $urandom_range(0, 3);
          end else begin
            gap++;
            hold_pending = 1'b1;
            hold_data = bus.O_rdata;
          end
        end
      end
    end
    check({name, "_finished"}, 32'(finished), 32'd1);
    check({name, "_protocol"}, viol, 0);
    check({name, "_addrvalid_gap"}, done_cycles, 1);
    if (wr) begin
      check({name, "_wr_count"}, wr_seen.size(), len);
      check({name, "_no_reads"}, rd_seen.size(), 0);
      for (int i = 0; i < wr_seen.size() && i < len; i++)
        check({name, "_wr_strobe"}, wr_seen[i], {addr, BCW'(i), bytes[i]});
    end else begin
      check({name, "_rd_count"}, rd_seen.size(), len);
      check({name, "_no_writes"}, wr_seen.size(), 0);
      check({name, "_rdata_count"}, got.size(), len);
      for (int i = 0; i < rd_seen.size() && i < len; i++)
        check({name, "_rd_strobe"}, rd_seen[i], {addr, BCW'(i), 8'h00});
      for (int i = 0; i < got.size() && i < len; i++)
        check({name, "_rdata"}, got[i], bytes[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[$];
    logic [7:0] bytes[$];
    logic [7:0] pat[3];
    int         av, lat, wcnt, stalls;
    logic       ok, w;
    logic [2:0] rdy_hist;
    int         len;

    bus.I_cmd_valid = 0; bus.I_cmd_write = 0; bus.I_cmd_addr = 0; bus.I_cmd_len = 0;
    bus.I_wdata = 0; bus.I_wdata_valid = 0; bus.I_rdata_ready = 0; bus.read_data = 0;
    reset_i = 1'b1;
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h3C;

    repeat (3) tick();
    check("reset_outputs", out_vec(), 32'h0);
    check("reset_bytecnt", 32'(bus.reg_bytecnt), 32'h0);
    reset_i = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(bus.O_cmd_ready), 32'd1);
    check("idle_busy", 32'(bus.O_busy), 32'd0);

    //          name        wr    addr   len  ws rs  strobes addrvalid-cycles
    vecs.push_back('{"wr8",      1'b1, 8'h21, 8,   0, 0,  8,   17});
    vecs.push_back('{"rd3",      1'b0, 8'h24, 3,   0, 0,  3,   10});
    vecs.push_back('{"rd2_stall",1'b0, 8'h30, 2,   0, 10, 2,   27});
    vecs.push_back('{"wr_len0",  1'b1, 8'h40, 0,   0, 0,  0,   1});
    vecs.push_back('{"rd_len0",  1'b0, 8'h41, 0,   0, 0,  0,   1});
    vecs.push_back('{"wr1",      1'b1, 8'h7F, 1,   0, 0,  1,   3});
    vecs.push_back('{"wr_gap2",  1'b1, 8'h10, 4,   2, 0,  4,   17});
    vecs.push_back('{"rd_max",   1'b0, 8'hFF, 127, 0, 0,  127, 382});
    vecs.push_back('{"wr_max",   1'b1, 8'h00, 127, 0, 0,  127, 255});

    foreach (vecs[v]) begin
      bytes.delete();
      for (int i = 0; i < vecs[v].len; i++)
        bytes.push_back(vecs[v].wr ? 8'((i + 1) * 8'h11) : (pat[i % 3] ^ 8'(i / 3)));
      do_burst(vecs[v].name, vecs[v].wr, vecs[v].addr, vecs[v].len,
               vecs[v].wstall, vecs[v].rstall, bytes, av, lat);
      check({vecs[v].name, "_strobes"}, vecs[v].wr ? wr_seen.size() : rd_seen.size(),
            vecs[v].exp_strobes);
      check({vecs[v].name, "_addrvalid_cycles"}, av, vecs[v].exp_av);
      if (!vecs[v].wr && vecs[v].len > 0) check({vecs[v].name, "_latency"}, lat, 3);
    end

    // Length-0 command: O_cmd_ready low for SETUP and DONE, then high again.
    wr_seen.delete(); rd_seen.delete();
    wait_ready("len0_seq", ok);
    bus.I_cmd_valid = 1'b1; bus.I_cmd_write = 1'b0; bus.I_cmd_addr = 8'h66; bus.I_cmd_len = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.I_cmd_valid = 1'b0;
      rdy_hist[2 - i] = bus.O_cmd_ready;
    end
    check("len0_ready_pattern", 32'(rdy_hist), 32'b001);
    check("len0_no_strobes", wr_seen.size() + rd_seen.size(), 0);

    // Reset in the middle of a write burst, right after the third strobe.
    wr_seen.delete(); viol = 0;
    wait_ready("rst_mid", ok);
    bus.I_cmd_valid = 1'b1; bus.I_cmd_write = 1'b1; bus.I_cmd_addr = 8'h21; bus.I_cmd_len = 7'd8;
    wcnt = 0;
    for (int i = 0; i < 100 && wr_seen.size() < 3; i++) begin
      tick();
      bus.I_cmd_valid   = 1'b0;
      bus.I_wdata_valid = bus.O_wdata_ready;
      if (bus.O_wdata_ready) begin
        wcnt++;
        bus.I_wdata = 8'(wcnt * 8'h11);
      end
    end
    check("rst_mid_reached_byte3", wr_seen.size(), 3);
    reset_i = 1'b1;
    bus.I_wdata_valid = 1'b1;
    tick();
    check("rst_mid_outputs", out_vec(), 32'h0);
    check("rst_mid_bytecnt", 32'(bus.reg_bytecnt), 32'h0);
    tick();
    reset_i = 1'b0;
    repeat (6) tick();
    check("rst_mid_no_more_writes", wr_seen.size(), 3);
    check("rst_mid_idle", {bus.O_busy, bus.reg_addrvalid, bus.O_cmd_ready}, 3'b001);
    bus.I_wdata_valid = 1'b0;

    // Randomized bursts against the transaction model.
    for (int t = 0; t < 40; t++) begin
      w   = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 24);
      bytes.delete();
      for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
      do_burst($sformatf("rnd%0d", t), w, 8'($urandom), len, -1, -1, bytes, av, lat);
      if (!w && len > 0) check($sformatf("rnd%0d_latency", t), lat, 3);
    end

`ifdef REG_MASTER_TIMEOUT_EN
    // Watchdog: one byte written, then write data withheld until the burst aborts.
    wr_seen.delete();
    wait_ready("tmo", ok);
    bus.I_cmd_valid = 1'b1; bus.I_cmd_write = 1'b1; bus.I_cmd_addr = 8'h55; bus.I_cmd_len = 7'd4;
    wcnt = 0; stalls = 0;
    for (int i = 0; i < 200 && !(i > 0 && !bus.O_busy); i++) begin
      tick();
      bus.I_cmd_valid   = 1'b0;
      bus.I_wdata_valid = 1'b0;
      if (bus.O_wdata_ready) begin
        if (wcnt == 0) begin
          bus.I_wdata_valid = 1'b1; bus.I_wdata = 8'h9C; wcnt++;
        end else stalls++;
      end
    end
    check("tmo_stall_cycles", stalls, 15);
    check("tmo_strobes", wr_seen.size(), 1);
    check("tmo_error", 32'(bus.O_error), 32'd1);
    check("tmo_addrvalid_low", 32'(bus.reg_addrvalid), 32'd0);
    bytes.delete();
    do_burst("tmo_next_cmd", 1'b0, 8'h12, 0, 0, 0, bytes, av, lat);
    check("tmo_error_sticky", 32'(bus.O_error), 32'd1);
`else
    check("error_tied_low", 32'(bus.O_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
